// File: rtl/draw_scheduler_pkg.sv
// draw_scheduler_pkg: shared definitions for the per-frame draw scheduler.
//   - Default pixel bus widths. The car/tower draw engines and the VGA adapter
//     use the same widths.
//   - Scheduler FSM state encoding.
package draw_scheduler_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_COORD_W   = 15;  // {y[6:0], x[7:0]}
  localparam int DEF_COLOUR_W  = 9;
  localparam int DEF_TIMEOUT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_START  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_NEXT   = 3'd4
  } sched_state_e;

endpackage

// File: rtl/draw_scheduler_if.sv
// draw_scheduler_if: frame-control, engine handshake and pixel bus between the
// draw engines and the scheduler.
//   master : engine/frame side. It drives frame_tick, req, done, wren_in,
//            coord_in and colour_in.
//   slave  : the scheduler. It drives start, grant, vga_* and the status flags.
// Per-engine buses are packed with engine i at [i*W +: W].
interface draw_scheduler_if
  import draw_scheduler_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int COORD_W  = DEF_COORD_W,
  parameter int COLOUR_W = DEF_COLOUR_W
);
  logic                          frame_tick;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            done;
  logic [NUM_REQ-1:0]            wren_in;
  logic [NUM_REQ*COORD_W-1:0]    coord_in;
  logic [NUM_REQ*COLOUR_W-1:0]   colour_in;
  logic [NUM_REQ-1:0]            start;
  logic [NUM_REQ-1:0]            grant;
  logic                          vga_wren;
  logic [COORD_W-1:0]            vga_coord;
  logic [COLOUR_W-1:0]           vga_colour;
  logic                          frame_busy;
  logic                          overrun;
  logic                          timeout_err;

  modport master (
    output frame_tick, req, done, wren_in, coord_in, colour_in,
    input  start, grant, vga_wren, vga_coord, vga_colour,
           frame_busy, overrun, timeout_err
  );

  modport slave (
    input  frame_tick, req, done, wren_in, coord_in, colour_in,
    output start, grant, vga_wren, vga_coord, vga_colour,
           frame_busy, overrun, timeout_err
  );
endinterface

// File: rtl/draw_scheduler_port_mux.sv
// draw_port_mux: zero-latency selector for the shared VGA write port.
//   idx        : index of the engine that owns the port
//   gnt_vld    : an engine currently holds the grant
//   wren_in, coord_in, colour_in : packed per-engine pixel buses
//   vga_wren, vga_coord, vga_colour : pixel of the owning engine. All are 0
//                                     when no engine holds the grant.
module draw_port_mux #(
  parameter int NUM_REQ  = 4,
  parameter int COORD_W  = 15,
  parameter int COLOUR_W = 9,
  parameter int IDX_W    = 2
) (
  input  logic [IDX_W-1:0]            idx,
  input  logic                        gnt_vld,
  input  logic [NUM_REQ-1:0]          wren_in,
  input  logic [NUM_REQ*COORD_W-1:0]  coord_in,
  input  logic [NUM_REQ*COLOUR_W-1:0] colour_in,
  output logic                        vga_wren,
  output logic [COORD_W-1:0]          vga_coord,
  output logic [COLOUR_W-1:0]         vga_colour
);
  // The packed 2-D layout matches the flat bus packing, so a plain assignment
  // reshapes the bus.
  logic [NUM_REQ-1:0][COORD_W-1:0]  coord_arr;
  logic [NUM_REQ-1:0][COLOUR_W-1:0] colour_arr;

  assign coord_arr  = coord_in;
  assign colour_arr = colour_in;

  always_comb begin
    vga_wren   = 1'b0;
    vga_coord  = '0;
    vga_colour = '0;
    if (gnt_vld) begin
      vga_wren   = wren_in[idx];
      vga_coord  = coord_arr[idx];
      vga_colour = colour_arr[idx];
    end
  end
endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: per-frame sequencer and arbiter for the VGA write port.
//   On each frame_tick it takes a snapshot of req. It then serves the engines
//   in that snapshot one at a time, in index order:
//     1. a 1-cycle start pulse to the engine,
//     2. the grant is held until the engine pulses done, or until the
//        watchdog expires,
//     3. the scheduler moves to the next index.
//   clk, reset : clock; asynchronous active-high reset
//   bus        : draw_scheduler_if.slave. It carries frame_tick, req, done and
//                the per-engine pixel buses in. It carries start, grant, the
//                vga_* pixel, frame_busy, and the sticky overrun/timeout_err
//                flags out.
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int COORD_W   = DEF_COORD_W,
  parameter int COLOUR_W  = DEF_COLOUR_W,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
  input logic              clk,
  input logic              reset,
  draw_scheduler_if.slave  bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  sched_state_e           state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_REQ-1:0]     snap_q, snap_d;
  logic [TIMEOUT_W-1:0]   wdog_q, wdog_d;
  logic [NUM_REQ-1:0]     start_q, start_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic                   tout_q, tout_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    wdog_d    = wdog_q;
    overrun_d = overrun_q;
    tout_d    = tout_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.frame_tick) begin
          snap_d  = bus.req;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      // Skip one index per cycle until a snapshotted requester is found.
      ST_SCAN: begin
        if (snap_q[idx_q])          state_d = ST_START;
        else if (idx_q == LAST_IDX) state_d = ST_IDLE;
        else                        idx_d   = idx_q + IDX_W'(1);
      end
      ST_START: begin
        wdog_d  = '0;
        state_d = ST_ACTIVE;
      end
      // done is only honoured here, and only from the granted engine.
      // An engine that stays silent is abandoned when the watchdog saturates.
      ST_ACTIVE: begin
        wdog_d = wdog_q + TIMEOUT_W'(1);
        if (bus.done[idx_q]) begin
          state_d = ST_NEXT;
        end else if (wdog_q == '1) begin
          tout_d  = 1'b1;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        snap_d[idx_q] = 1'b0;
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SCAN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A tick outside IDLE is dropped and flagged. This includes the
    // NEXT->IDLE cycle of the last engine.
    if (bus.frame_tick && (state_q != ST_IDLE)) overrun_d = 1'b1;

    // Outputs are registered, so they are decoded from the next state.
    start_d = '0;
    grant_d = '0;
    if (state_d == ST_START || state_d == ST_ACTIVE) grant_d[idx_d] = 1'b1;
    if (state_d == ST_START)                         start_d[idx_d] = 1'b1;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      snap_q    <= '0;
      wdog_q    <= '0;
      start_q   <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      wdog_q    <= wdog_d;
      start_q   <= start_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      tout_q    <= tout_d;
    end
  end

  assign bus.start       = start_q;
  assign bus.grant       = grant_q;
  assign bus.frame_busy  = busy_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = tout_q;

  // grant_q is one-hot at idx_q whenever it is nonzero, so idx_q selects the owner.
  draw_port_mux #(
    .NUM_REQ  (NUM_REQ),
    .COORD_W  (COORD_W),
    .COLOUR_W (COLOUR_W),
    .IDX_W    (IDX_W)
  ) u_mux (
    .idx        (idx_q),
    .gnt_vld    (|grant_q),
    .wren_in    (bus.wren_in),
    .coord_in   (bus.coord_in),
    .colour_in  (bus.colour_in),
    .vga_wren   (bus.vga_wren),
    .vga_coord  (bus.vga_coord),
    .vga_colour (bus.vga_colour)
  );
endmodule

// File: tb/tb_draw_scheduler.sv
module tb_draw_scheduler;
  localparam int N = 4, CW = 15, KW = 9, TW = 4, DONE_DLY = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  draw_scheduler_if #(.NUM_REQ(N), .COORD_W(CW), .COLOUR_W(KW)) bus();

  draw_scheduler #(.NUM_REQ(N), .COORD_W(CW), .COLOUR_W(KW), .TIMEOUT_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];          // expected order of start pulses
  int last_start = -1;
  logic [N-1:0] hang = '0;
  int cnt [N];
  bit armed [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Scoreboard monitor: start pulses are popped in order. The port owner and
  // the vga pixel are checked every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.start != '0) begin
        chk("start_onehot", 32'($onehot(bus.start)), 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL start_unexpected: got start=%b expected none", bus.start);
        end else begin
          chk("start_idx", 32'(idx_of(bus.start)), 32'(exp_q.pop_front()));
        end
        last_start = idx_of(bus.start);
      end
      if (bus.grant == '0) begin
        chk("vga_idle", 32'({bus.vga_wren, bus.vga_coord, bus.vga_colour}), 32'd0);
      end else if (last_start < 0) begin
        n_cmp++; n_err++;
        $display("FAIL grant_no_start: got grant=%b expected 0", bus.grant);
      end else begin
        chk("grant_owner", 32'(bus.grant), 32'(1 << last_start));
        chk("vga_port", 32'({bus.vga_wren, bus.vga_coord, bus.vga_colour}),
            32'({bus.wren_in[last_start], bus.coord_in[last_start*CW +: CW],
                 bus.colour_in[last_start*KW +: KW]}));
      end
    end
  end

  // Engine model: done pulses DONE_DLY cycles after start, unless the engine hangs.
  initial begin
    bus.done = '0;
    forever begin
      @(negedge clk);
      bus.done = '0;
      for (int i = 0; i < N; i++) begin
        if (reset) begin
          armed[i] = 1'b0;
        end else if (bus.start[i]) begin
          armed[i] = !hang[i];
          cnt[i]   = DONE_DLY;
        end else if (armed[i]) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            bus.done[i] = 1'b1;
            armed[i]    = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic wait_grant(input string name, input int i, input int bound);
    int c = 0;
    while (!bus.grant[i] && c < bound) begin @(negedge clk); c++; end
    chk(name, 32'(bus.grant[i]), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int c = 0;
    while (bus.frame_busy && c < bound) begin @(negedge clk); c++; end
    chk(name, 32'(bus.frame_busy), 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.req        = '0;
    bus.wren_in    = 4'b1101;
    bus.coord_in   = {15'h0333, 15'h0222, 15'h0111, 15'h1234};
    bus.colour_in  = {9'h0D3, 9'h0C2, 9'h0B1, 9'h1A0};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_start_grant", 32'({bus.start, bus.grant}), 32'd0);
    chk("rst_vga", 32'({bus.vga_wren, bus.vga_coord, bus.vga_colour}), 32'd0);
    chk("rst_flags", 32'({bus.frame_busy, bus.overrun, bus.timeout_err}), 32'd0);

    // All four engines in order; engine 0 drives a pixel during grant[1].
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    tick();
    chk("t1_busy", 32'(bus.frame_busy), 32'd1);
    wait_grant("t3_grant1", 1, 100);
    chk("t3_vga_wren", 32'(bus.vga_wren), 32'd0);
    chk("t3_vga_coord", 32'(bus.vga_coord), 32'h0111);
    chk("t3_vga_colour", 32'(bus.vga_colour), 32'h0B1);
    wait_idle("t1_idle", 200);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);
    chk("t1_no_overrun", 32'(bus.overrun), 32'd0);

    // Sparse snapshot; req changes after the snapshot are ignored.
    bus.req = 4'b0101;
    exp_q.push_back(0); exp_q.push_back(2);
    tick();
    bus.req = 4'b1111;
    wait_idle("t2_idle", 200);
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // Engine 2 hangs: the watchdog abandons it and the grant moves to engine 3.
    hang    = 4'b0100;
    bus.req = 4'b1100;
    exp_q.push_back(2); exp_q.push_back(3);
    tick();
    wait_grant("t4_grant2", 2, 50);
    repeat (10) @(negedge clk);
    chk("t4_no_early_tout", 32'(bus.timeout_err), 32'd0);
    wait_grant("t4_grant3", 3, 50);
    chk("t4_timeout", 32'(bus.timeout_err), 32'd1);
    wait_idle("t4_idle", 200);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);
    hang = '0;

    // A tick mid-frame is an overrun; the frame completes and does not restart.
    bus.req = 4'b0011;
    exp_q.push_back(0); exp_q.push_back(1);
    tick();
    wait_grant("t5_grant1", 1, 100);
    tick();
    chk("t5_overrun", 32'(bus.overrun), 32'd1);
    wait_idle("t5_idle", 200);
    repeat (20) @(negedge clk);
    chk("t5_no_restart", 32'(bus.frame_busy), 32'd0);
    chk("t5_drained", 32'(exp_q.size()), 32'd0);
    chk("t5_sticky_tout", 32'(bus.timeout_err), 32'd1);

    // An asynchronous reset mid-ACTIVE clears everything; the next frame starts at idx 0.
    bus.req = 4'b1111;
    exp_q.push_back(0);
    tick();
    wait_grant("t6_grant0", 0, 50);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_grant", 32'({bus.start, bus.grant}), 32'd0);
    chk("t6_async_vga", 32'({bus.vga_wren, bus.vga_coord, bus.vga_colour}), 32'd0);
    chk("t6_async_flags", 32'({bus.frame_busy, bus.overrun, bus.timeout_err}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_drained_pre", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    tick();
    wait_idle("t6_idle", 200);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
